// File: rtl/window_mac_accum_pkg.sv
// ---------------------------------------------------------------------------
// window_mac_accum_pkg : shared defaults and FSM encoding for window_mac_accum
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package window_mac_accum_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int IDX_W_DEF  = 10;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/window_mac_accum_pipe_delay.sv
// ---------------------------------------------------------------------------
// pipe_delay : DEPTH-stage register delay line with synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/window_mac_accum.sv
// ---------------------------------------------------------------------------
// window_mac_accum : per-window multiply-accumulate with best-window tracking
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module window_mac_accum
  import window_mac_accum_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_win_last,
  input  logic             i_frame_done,
  input  logic [PIX_W-1:0] i_pix_lg,
  input  logic [PIX_W-1:0] i_pix_si,
  output logic [ACC_W-1:0] o_acc_out,
  output logic             o_acc_valid,
  output logic [IDX_W-1:0] o_win_idx,
  output logic [ACC_W-1:0] o_best_sum,
  output logic [IDX_W-1:0] o_best_idx,
  output logic             o_best_valid
);

  logic [1:0]         w_ctl_dly;
  logic               w_v0;
  logic               w_l0;
  logic               r_fd_prev;
  logic               w_fd_rise;
  logic               w_fd_late;
  logic [2*PIX_W-1:0] r_prod;
  logic               r_v1;
  logic               r_l1;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_add;
  logic [ACC_W-1:0]   r_acc;
  logic               r_first;
  logic               r_acc_valid;
  logic               w_acc_valid;
  logic [IDX_W-1:0]   r_win_idx;
  logic [ACC_W-1:0]   r_best_sum;
  logic [IDX_W-1:0]   r_best_idx;
  logic               r_best_first;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_restart;

  // Align enable/win_last with the BRAM read data.
  pipe_delay #(.WIDTH(2), .DEPTH(RD_LAT)) u_ctl_dly (
    .clk   (clk),
    .reset (reset),
    .i_d   ({i_enable, i_win_last}),
    .o_q   (w_ctl_dly)
  );
  assign w_v0 = w_ctl_dly[1];
  assign w_l0 = w_ctl_dly[0];

  // Done edge arrives one cycle after the final best update would be visible.
  assign w_fd_rise = i_frame_done & ~r_fd_prev;
  pipe_delay #(.WIDTH(1), .DEPTH(RD_LAT + 1)) u_done_dly (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_fd_rise),
    .o_q   (w_fd_late)
  );

  assign w_prod_ext = ACC_W'(r_prod);
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_acc_add  = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fd_prev   <= 1'b0;
      r_prod      <= '0;
      r_v1        <= 1'b0;
      r_l1        <= 1'b0;
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_acc_valid <= 1'b0;
    end else begin
      r_fd_prev   <= i_frame_done;
      r_prod      <= i_pix_lg * i_pix_si;
      r_v1        <= w_v0;
      r_l1        <= w_l0;
      r_acc_valid <= r_v1 & r_l1;
      if (r_v1) begin
        r_acc   <= r_first ? w_prod_ext : w_acc_add;
        r_first <= r_l1;
      end
    end
  end

  assign w_acc_valid = r_acc_valid & (r_state != DONE);

  always_ff @(posedge clk) begin
    if (reset || w_restart) begin
      r_win_idx    <= '0;
      r_best_sum   <= '0;
      r_best_idx   <= '0;
      r_best_first <= 1'b1;
    end else if (w_acc_valid) begin
      r_win_idx <= r_win_idx + IDX_W'(1);
      if (r_best_first || (r_acc > r_best_sum)) begin
        r_best_sum   <= r_acc;
        r_best_idx   <= r_win_idx;
        r_best_first <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: if (i_enable) w_state_nxt = RUN;
      RUN:  if (w_fd_late) w_state_nxt = DONE;
      DONE: begin
        if (i_enable && !i_frame_done) begin
          w_state_nxt = RUN;
          w_restart   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_acc_out    = r_acc;
  assign o_acc_valid  = w_acc_valid;
  assign o_win_idx    = r_win_idx;
  assign o_best_sum   = r_best_sum;
  assign o_best_idx   = r_best_idx;
  assign o_best_valid = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_window_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_window_mac_accum : three configurations driven together against a window-sum model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_window_mac_accum;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       wl = 1'b0;
  logic       fd = 1'b0;
  logic [7:0] a_lg = 8'd0;
  logic [7:0] a_si = 8'd0;
  logic [15:0] d1, d2, d3;

  always #5 clk = ~clk;

  // BRAM read model: data appears RD_LAT cycles after its address cycle
  always @(posedge clk) begin
    d1 <= {a_lg, a_si};
    d2 <= d1;
    d3 <= d2;
  end

  logic [31:0] acc_a, bs_a, acc_c, bs_c;
  logic [15:0] acc_b, bs_b;
  logic [9:0]  idx_a, bi_a, idx_b, bi_b, idx_c, bi_c;
  logic        v_a, bv_a, v_b, bv_b, v_c, bv_c;

  window_mac_accum #(.ACC_W(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .i_enable(en), .i_win_last(wl), .i_frame_done(fd),
    .i_pix_lg(d1[15:8]), .i_pix_si(d1[7:0]), .o_acc_out(acc_a), .o_acc_valid(v_a),
    .o_win_idx(idx_a), .o_best_sum(bs_a), .o_best_idx(bi_a), .o_best_valid(bv_a));

  window_mac_accum #(.ACC_W(16), .RD_LAT(1)) u_dut_b (
    .clk(clk), .reset(reset), .i_enable(en), .i_win_last(wl), .i_frame_done(fd),
    .i_pix_lg(d1[15:8]), .i_pix_si(d1[7:0]), .o_acc_out(acc_b), .o_acc_valid(v_b),
    .o_win_idx(idx_b), .o_best_sum(bs_b), .o_best_idx(bi_b), .o_best_valid(bv_b));

  window_mac_accum #(.ACC_W(32), .RD_LAT(3)) u_dut_c (
    .clk(clk), .reset(reset), .i_enable(en), .i_win_last(wl), .i_frame_done(fd),
    .i_pix_lg(d3[15:8]), .i_pix_si(d3[7:0]), .o_acc_out(acc_c), .o_acc_valid(v_c),
    .o_win_idx(idx_c), .o_best_sum(bs_c), .o_best_idx(bi_c), .o_best_valid(bv_c));

  logic [31:0] o_acc [3];
  logic [31:0] o_bs  [3];
  logic [9:0]  o_idx [3];
  logic [9:0]  o_bi  [3];
  logic        o_v   [3];
  logic        o_bv  [3];

  assign o_acc[0] = acc_a;           assign o_acc[1] = {16'd0, acc_b}; assign o_acc[2] = acc_c;
  assign o_bs[0]  = bs_a;            assign o_bs[1]  = {16'd0, bs_b};  assign o_bs[2]  = bs_c;
  assign o_idx[0] = idx_a;           assign o_idx[1] = idx_b;          assign o_idx[2] = idx_c;
  assign o_bi[0]  = bi_a;            assign o_bi[1]  = bi_b;           assign o_bi[2]  = bi_c;
  assign o_v[0]   = v_a;             assign o_v[1]   = v_b;            assign o_v[2]   = v_c;
  assign o_bv[0]  = bv_a;            assign o_bv[1]  = bv_b;           assign o_bv[2]  = bv_c;

  typedef struct {
    int     dut;
    longint sum;
    int     idx;
    longint due;
  } exp_t;

  exp_t   exq[$];
  longint cyc;
  int     checks;
  int     errors;
  longint run_sum [3];
  int     widx    [3];
  longint done_at [3];
  longint fsum    [3][64];
  int     fcnt    [3];
  longint maxv    [3];
  int     lat     [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Best window of the current frame: largest sum, earliest index on ties.
  function automatic void best_of(input int k, output longint bs, output int bi);
    bs = 0;
    bi = 0;
    for (int i = 0; i < fcnt[k]; i++) begin
      if (i == 0 || fsum[k][i] > bs) begin
        bs = fsum[k][i];
        bi = i % 1024;
      end
    end
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int     qi;
      logic   ev;
      logic   bv;
      longint bsum;
      int     bidx;
      qi = -1;
      for (int i = 0; i < exq.size(); i++)
        if (qi < 0 && exq[i].dut == k) qi = i;
      ev = (qi >= 0) && (exq[qi].due == cyc);
      chk($sformatf("acc_valid[%0d]@%0d", k, cyc), 64'(o_v[k]), 64'(ev));
      if (ev) begin
        chk($sformatf("acc_out[%0d]@%0d", k, cyc), 64'(o_acc[k]), 64'(exq[qi].sum));
        chk($sformatf("win_idx[%0d]@%0d", k, cyc), 64'(o_idx[k]), 64'(exq[qi].idx));
        exq.delete(qi);
      end
      bv = (done_at[k] >= 0) && (cyc >= done_at[k]);
      chk($sformatf("best_valid[%0d]@%0d", k, cyc), 64'(o_bv[k]), 64'(bv));
      if (bv) begin
        best_of(k, bsum, bidx);
        chk($sformatf("best_sum[%0d]@%0d", k, cyc), 64'(o_bs[k]), 64'(bsum));
        chk($sformatf("best_idx[%0d]@%0d", k, cyc), 64'(o_bi[k]), 64'(bidx));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    wl = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; en = 1'b0; wl = 1'b0; fd = 1'b0;
    exq.delete();
    for (int k = 0; k < 3; k++) begin
      run_sum[k] = 0; widx[k] = 0; done_at[k] = -1; fcnt[k] = 0;
    end
    repeat (n) step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_acc_out[%0d]", k), 64'(o_acc[k]), 64'd0);
      chk($sformatf("rst_win_idx[%0d]", k), 64'(o_idx[k]), 64'd0);
      chk($sformatf("rst_best_sum[%0d]", k), 64'(o_bs[k]), 64'd0);
      chk($sformatf("rst_best_idx[%0d]", k), 64'(o_bi[k]), 64'd0);
    end
  endtask

  task automatic send_pix(input int lg, input int si, input bit last);
    en = 1'b1; wl = last; a_lg = lg[7:0]; a_si = si[7:0];
    for (int k = 0; k < 3; k++) begin
      run_sum[k] = run_sum[k] + longint'(lg * si);
      if (run_sum[k] > maxv[k]) run_sum[k] = maxv[k];
      if (last) begin
        exq.push_back('{k, run_sum[k], widx[k], cyc + lat[k] + 2});
        fsum[k][fcnt[k]] = run_sum[k];
        fcnt[k]++;
        widx[k] = (widx[k] + 1) % 1024;
        run_sum[k] = 0;
      end
    end
    step();
    en = 1'b0;
    wl = 1'b0;
  endtask

  task automatic start_frame(input int lg, input int si, input bit last);
    fd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      done_at[k] = -1; widx[k] = 0; fcnt[k] = 0;
    end
    send_pix(lg, si, last);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("restart_best_sum[%0d]", k), 64'(o_bs[k]), 64'd0);
      chk($sformatf("restart_best_idx[%0d]", k), 64'(o_bi[k]), 64'd0);
    end
  endtask

  task automatic end_frame();
    fd = 1'b1;
    for (int k = 0; k < 3; k++) done_at[k] = cyc + lat[k] + 2;
    repeat (3) step();
    fd = 1'b0;
    idle(7);
    for (int k = 0; k < 3; k++)
      chk($sformatf("frame_best_valid[%0d]", k), 64'(o_bv[k]), 64'd1);
  endtask

  task automatic rand_frame(input int nwin);
    for (int w = 0; w < nwin; w++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int p = 0; p < len; p++) begin
        int lg, si;
        lg = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
        si = $urandom_range(0, 255);
        if (w == 0 && p == 0) begin
          start_frame(lg, si, (p == len - 1));
        end else begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send_pix(lg, si, (p == len - 1));
        end
      end
    end
    end_frame();
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    maxv[0] = 64'hFFFF_FFFF; maxv[1] = 64'hFFFF; maxv[2] = 64'hFFFF_FFFF;
    lat[0] = 1; lat[1] = 1; lat[2] = 3;
    for (int k = 0; k < 3; k++) begin
      run_sum[k] = 0; widx[k] = 0; done_at[k] = -1; fcnt[k] = 0;
    end

    do_reset(3);

    // 3x3 window of 2*3
    start_frame(2, 3, 1'b0);
    repeat (7) send_pix(2, 3, 1'b0);
    send_pix(2, 3, 1'b1);
    end_frame();
    chk("t1_best_sum", 64'(bs_a), 64'd54);

    // window sums 10,40,40,5: tie keeps the earlier index
    start_frame(10, 1, 1'b1);
    send_pix(40, 1, 1'b1);
    send_pix(40, 1, 1'b1);
    send_pix(5, 1, 1'b1);
    end_frame();
    chk("t2_best_sum", 64'(bs_a), 64'd40);
    chk("t2_best_idx", 64'(bi_a), 64'd1);
    chk("t2_best_idx_lat3", 64'(bi_c), 64'd1);

    // enable toggling within a window, then saturation on the 16-bit accumulator
    start_frame(1, 1, 1'b0);
    idle(1); send_pix(1, 1, 1'b0);
    idle(1); send_pix(1, 1, 1'b0);
    idle(1); send_pix(1, 1, 1'b1);
    send_pix(255, 255, 1'b0);
    send_pix(255, 255, 1'b1);
    end_frame();
    chk("t4_sat16_best", 64'(bs_b), 64'hFFFF);
    chk("t4_wide_best", 64'(bs_a), 64'd130050);

    // reset just before the closing pixel discards the partial window
    start_frame(3, 3, 1'b0);
    send_pix(3, 3, 1'b0);
    do_reset(2);
    idle(6);
    start_frame(4, 4, 1'b0);
    send_pix(4, 4, 1'b1);
    end_frame();
    chk("t5_best_sum", 64'(bs_a), 64'd32);

    for (int f = 0; f < 4; f++) rand_frame($urandom_range(5, 10));

    idle(4);
    chk("pending_windows", 64'(exq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
